// File: rtl/imem_access_ctrl.sv
// Instruction memory port owner: power-up load sequencing, fetch grant and registered fetch output.
// Latency: grants are combinational; if_instr/if_valid update 1 cycle after if_gnt.
// Backpressure: if_stall holds if_instr/if_valid and blocks if_gnt; loader waits while ld_gnt=0.
//
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_boot_start                        start (re)load of the program image
//   i_ld_req/i_ld_addr/i_ld_data/i_ld_last, o_ld_gnt   loader write channel
//   i_if_req/i_if_addr/i_if_stall, o_if_gnt            fetch request channel
//   o_if_valid/o_if_instr               registered fetched word
//   o_mem_addr/o_mem_we/o_mem_wdata, i_mem_rdata       single memory port
//   o_core_run                          core may execute
//
// Optional build macro IMEM_RUNTIME_LOAD_EN: loader writes in RUN, arbitrated against fetch,
// with a forced loader grant after STARVE_MAX consecutive denied cycles.
module imem_access_ctrl #(
  parameter int          ADDR_W     = 12,
  parameter int          STARVE_MAX = 4,
  parameter logic [15:0] NOP_WORD   = 16'hB000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_boot_start,
  input  logic        i_ld_req,
  input  logic [15:0] i_ld_addr,
  input  logic [15:0] i_ld_data,
  input  logic        i_ld_last,
  output logic        o_ld_gnt,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  input  logic        i_if_stall,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [15:0] o_if_instr,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  output logic        o_core_run
);

  typedef enum logic [1:0] {S_IDLE, S_BOOT, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_if_gnt_raw;
  logic   w_forced;
  logic   w_ld_gnt;
  logic   w_if_gnt;
  logic   w_unused;

  // Address bits above ADDR_W are dropped without any error indication.
  assign w_unused = ^{i_ld_addr[15:ADDR_W], i_if_addr[15:ADDR_W], 1'(STARVE_MAX)};

  assign w_if_gnt_raw = i_if_req & ~i_if_stall;

`ifdef IMEM_RUNTIME_LOAD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Loader has waited long enough: it takes the port even if fetch wants it.
  assign w_forced = (r_wait_cnt == CNT_W'(STARVE_MAX)) & i_ld_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state != S_RUN) || !i_ld_req || w_ld_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CNT_W'(STARVE_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_forced = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_gnt    = 1'b0;
    w_if_gnt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_boot_start) w_state_nxt = S_BOOT;
      end
      S_BOOT: begin
        w_ld_gnt = i_ld_req;
        if (i_ld_req && i_ld_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // A reload request takes precedence over a fetch in the same cycle.
        w_if_gnt = w_if_gnt_raw & ~w_forced & ~i_boot_start;
`ifdef IMEM_RUNTIME_LOAD_EN
        w_ld_gnt = i_ld_req & (w_forced | ~w_if_gnt_raw);
`endif
        if (i_boot_start) w_state_nxt = S_BOOT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_ld_gnt    = w_ld_gnt;
  assign o_if_gnt    = w_if_gnt;
  assign o_mem_we    = w_ld_gnt;
  assign o_mem_wdata = w_ld_gnt ? i_ld_data : 16'h0000;
  assign o_mem_addr  = w_ld_gnt ? {{(16-ADDR_W){1'b0}}, i_ld_addr[ADDR_W-1:0]} :
                       w_if_gnt ? {{(16-ADDR_W){1'b0}}, i_if_addr[ADDR_W-1:0]} :
                                  16'h0000;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_core_run <= 1'b0;
      o_if_valid <= 1'b0;
      o_if_instr <= NOP_WORD;
    end else begin
      if ((r_state == S_BOOT) && (w_state_nxt == S_RUN)) begin
        o_core_run <= 1'b1;
      end
      if (r_state == S_RUN) begin
        if (i_boot_start) begin
          o_core_run <= 1'b0;
          o_if_valid <= 1'b0;
          o_if_instr <= NOP_WORD;
        end else if (w_if_gnt) begin
          o_if_instr <= i_mem_rdata;
          o_if_valid <= 1'b1;
        end else if (!i_if_stall) begin
          o_if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
module tb_imem_access_ctrl;
  localparam int          STARVE = 4;
  localparam logic [15:0] NOP    = 16'hB000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_start, ld_req, ld_last, if_req, if_stall;
  logic [15:0] ld_addr, ld_data, if_addr;
  logic        ld_gnt, if_gnt, if_valid, mem_we, core_run;
  logic [15:0] if_instr, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_access_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_boot_start(boot_start),
    .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .i_ld_last(ld_last),
    .o_ld_gnt(ld_gnt), .i_if_req(if_req), .i_if_addr(if_addr), .i_if_stall(if_stall),
    .o_if_gnt(if_gnt), .o_if_valid(if_valid), .o_if_instr(if_instr),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_core_run(core_run)
  );

  // Environment memory: combinational read, write on the clock edge.
  logic [15:0] mem [4096];
  assign mem_rdata = mem[mem_addr[11:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: image contents as the loader wrote them, plus block mode and outputs.
  logic [15:0] ref_img [4096];
  int          mode;      // 0 idle, 1 boot, 2 run
  int          denied;    // consecutive cycles the loader asked and was refused in run
  bit          m_core_run, m_valid;
  logic [15:0] m_instr;
  logic [15:0] sb_q[$];
  bit          smp_ld_gnt, smp_if_gnt;

  task automatic model_reset();
    mode = 0; denied = 0; m_core_run = 0; m_valid = 0; m_instr = NOP;
    sb_q.delete();
  endtask

  // One clock cycle: inputs are already driven; check at negedge, advance model, return after posedge.
  task automatic cycle();
    bit want, force_ld, e_ld, e_if;
    logic [15:0] e_addr;
    @(negedge clk);
    want = if_req && !if_stall;
    force_ld = 0; e_ld = 0; e_if = 0;
    if (mode == 1) e_ld = ld_req;
    else if (mode == 2) begin
`ifdef IMEM_RUNTIME_LOAD_EN
      force_ld = ld_req && (denied >= STARVE);
      e_ld = ld_req && (force_ld || !want);
`endif
      e_if = want && !force_ld && !boot_start;
    end
    e_addr = e_ld ? (ld_addr & 16'h0FFF) : e_if ? (if_addr & 16'h0FFF) : 16'h0000;
    chk("ld_gnt", ld_gnt, e_ld);
    chk("if_gnt", if_gnt, e_if);
    chk("mem_we", mem_we, e_ld);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_ld ? ld_data : 16'h0000);
    chk("core_run", core_run, m_core_run);
    chk("if_valid", if_valid, m_valid);
    chk("if_instr", if_instr, m_instr);
    smp_ld_gnt = ld_gnt;
    smp_if_gnt = if_gnt;
    if (e_if) sb_q.push_back(ref_img[if_addr[11:0]]);
    if (e_ld) ref_img[ld_addr[11:0]] = ld_data;
    case (mode)
      0: if (boot_start) mode = 1;
      1: if (e_ld && ld_last) begin mode = 2; m_core_run = 1; end
      default: begin
        if (ld_req && !e_ld) denied = (denied < STARVE) ? denied + 1 : STARVE;
        else denied = 0;
        if (boot_start) begin
          mode = 1; m_core_run = 0; m_valid = 0; m_instr = NOP; denied = 0;
        end else if (e_if) begin
          m_valid = 1; m_instr = ref_img[if_addr[11:0]];
        end else if (!if_stall) m_valid = 0;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every granted fetch must appear on if_instr after the next edge.
  bit mon_gnt = 0;
  always @(negedge clk) mon_gnt = if_gnt;
  always @(posedge clk) begin
    #2;
    if (mon_gnt && rst_n) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_unexpected_fetch: got %0h expected none", if_instr);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        chk("sb_fetch_word", if_instr, e);
        chk("sb_fetch_valid", if_valid, 1);
      end
    end
  end

  task automatic clear_inputs();
    boot_start = 0; ld_req = 0; ld_last = 0; if_req = 0; if_stall = 0;
    ld_addr = 0; ld_data = 0; if_addr = 0;
  endtask

  task automatic goto_run();
    for (int k = 0; k < 4 && mode != 2; k++) begin
      clear_inputs();
      if (mode == 0) boot_start = 1;
      else begin
        ld_req = 1; ld_last = 1;
        ld_addr = 16'($urandom) & 16'hF00F; ld_data = 16'($urandom);
      end
      cycle();
    end
    clear_inputs();
    cycle();
    chk("goto_run_core_run", core_run, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] boot_data [3];
  bit          gnt_ld [1:8];
  bit          gnt_if [1:8];
  int          first_ld;

  initial begin
    boot_data[0] = 16'h1111; boot_data[1] = 16'h2222; boot_data[2] = 16'h3333;
    for (int i = 0; i < 4096; i++) begin mem[i] = 16'h0000; ref_img[i] = 16'h0000; end
    clear_inputs();
    model_reset();
    rst_n = 0;
    ld_req = 1; if_req = 1;
    #12;
    chk("rst_core_run", core_run, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    clear_inputs();
    #4 rst_n = 1;

    // Boot load of three words, last one flagged.
    boot_start = 1; cycle(); boot_start = 0;
    for (int k = 0; k < 3; k++) begin
      ld_req = 1; ld_addr = 16'(k); ld_data = boot_data[k]; ld_last = (k == 2);
      if_req = 1;
      cycle();
      if (k < 2) chk("boot_core_run_low", core_run, 0);
    end
    chk("boot_core_run_high", core_run, 1);
    clear_inputs();

    // Fetch latency.
    if_req = 1; if_addr = 16'h0001; cycle();
    chk("fetch_valid", if_valid, 1);
    chk("fetch_instr", if_instr, 16'h2222);

    // Stall hold.
    if_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_valid", if_valid, 1);
      chk("stall_instr", if_instr, 16'h2222);
    end

    // Reload during an active fetch.
    if_stall = 0; if_addr = 16'h0002; boot_start = 1; cycle();
    chk("reload_core_run", core_run, 0);
    chk("reload_valid", if_valid, 0);
    chk("reload_instr", if_instr, 16'hB000);
    clear_inputs();

    // Async reset mid-boot, between edges, with a loader request pending.
    ld_req = 1; ld_addr = 16'h0005; ld_data = 16'h5A5A; cycle();
    #2 rst_n = 0;
    #1;
    chk("arst_ld_gnt", ld_gnt, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_core_run", core_run, 0);
    chk("arst_if_instr", if_instr, NOP);
    model_reset();
    clear_inputs();
    @(posedge clk); #1 rst_n = 1;
    cycle();

    // Randomized traffic.
    goto_run();
    for (int n = 0; n < 300; n++) begin
      boot_start = ($urandom % 40) == 0;
      if_req     = ($urandom % 4) != 0;
      if_stall   = ($urandom % 4) == 0;
      ld_req     = (mode == 1) ? (($urandom % 2) == 0) : (($urandom % 3) == 0);
      ld_last    = ($urandom % 5) == 0;
      ld_addr    = 16'($urandom) & 16'hF00F;
      ld_data    = 16'($urandom);
      if_addr    = 16'($urandom) & 16'hF00F;
      cycle();
    end

    // Loader starvation under continuous fetch.
    goto_run();
    if_req = 1; ld_req = 1; ld_last = 1;
    for (int i = 1; i <= 8; i++) begin
      if_addr = 16'($urandom) & 16'h000F;
      ld_addr = 16'h0F00 + 16'(i); ld_data = 16'($urandom);
      cycle();
      gnt_ld[i] = smp_ld_gnt;
      gnt_if[i] = smp_if_gnt;
    end
    first_ld = 0;
    for (int i = 8; i >= 1; i--) if (gnt_ld[i]) first_ld = i;
`ifdef IMEM_RUNTIME_LOAD_EN
    chk("starve_first_ld_gnt", first_ld, 5);
    chk("starve_if_gnt_c5", gnt_if[5], 0);
`else
    chk("starve_first_ld_gnt", first_ld, 0);
    chk("starve_if_gnt_c5", gnt_if[5], 1);
`endif
    chk("starve_if_gnt_c6", gnt_if[6], 1);
    chk("starve_core_run", core_run, 1);
    clear_inputs();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
